clk_divider_n: RTL and testbench
================================

CLK_DIVIDER_N -- requirements
Module: clk_divider_n

Interface
REQ-001 Parameter WIDTH, default 8: width of divisor ports and internal counter.
REQ-002 Parameter RESET_DIV, default 3: divisor loaded at reset (clamped per REQ-010).
REQ-003 clk  input  1  input clock; sole clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run request; sampled only per REQ-013/REQ-014.
REQ-006 div_val  input  WIDTH  requested divisor N, unsigned.
REQ-007 div_load  input  1  single-cycle strobe capturing div_val.
REQ-008 clk_div  output  1  divided clock, posedge-registered, duty floor(N/2)/N.
REQ-009 clk_div_50  output  1  divided clock, 50% duty for every N>=2; div_active  output  WIDTH  divisor in use; tick  output  1  period-start pulse.

Function
REQ-010 A captured divisor of 0 or 1 SHALL be stored as 2; the maximum divisor is 2^WIDTH-1.
REQ-011 The block SHALL have two states, IDLE and RUN, and a counter cnt that runs 0..N-1 in RUN.
REQ-012 In RUN, cnt SHALL increment each posedge and wrap from N-1 to 0; a wrap marks the period boundary.
REQ-013 IDLE->RUN SHALL occur at the first posedge with en=1; the first RUN cycle has cnt=0.
REQ-014 RUN->IDLE SHALL occur only at a period boundary with en=0; a partial period is never truncated.
REQ-015 In IDLE, cnt SHALL be 0 and clk_div, tick SHALL be 0.
REQ-016 clk_div SHALL be a flop output, high exactly in RUN cycles with cnt < floor(N/2), low otherwise.
REQ-017 A negedge flop SHALL sample clk_div; clk_div_50 = clk_div OR (odd AND negedge flop), where odd is a registered flag equal to N[0] of div_active.
REQ-018 clk_div_50 SHALL be glitch-free; odd SHALL change only at a period boundary or in IDLE.
REQ-019 tick SHALL be high for exactly the cycle cnt=0 in RUN.
REQ-020 div_load in RUN SHALL write div_val into a pending register; the pending value SHALL become div_active at the next period boundary.
REQ-021 Multiple div_load strobes within one period: last one wins.
REQ-022 A div_load on the boundary edge itself SHALL take effect at the following boundary; the boundary uses the pending value held before that edge.
REQ-023 div_load in IDLE SHALL update div_active and pending on that edge.
REQ-024 The high phase and the low phase of any period SHALL use one N only; no mixed-ratio periods.

Reset
REQ-025 On reset low, asynchronously: state=IDLE, cnt=0, clk_div=0, negedge flop=0, clk_div_50=0, tick=0.
REQ-026 On reset low: div_active, pending = clamp(RESET_DIV); odd = clamp(RESET_DIV)[0].
REQ-027 Release SHALL be synchronous to the next posedge; the block starts per REQ-013.

Verification
REQ-028 Reset, then en=1, RESET_DIV=3 -> clk_div 1,0,0 repeating; clk_div_50 high 1.5 clk cycles per 3; tick every 3rd cycle.
REQ-029 N=3 running, div_load with div_val=4 at cnt=1 -> current period completes at 3 cycles; then clk_div 1,1,0,0; clk_div_50 equals clk_div; div_active=4 from the boundary.
REQ-030 div_load 5 and then 7 in one period -> 7 applied. div_load 9 on a boundary edge -> one more period at the old N, then 9.
REQ-031 div_val=0 and div_val=1 loaded -> div_active=2; clk_div_50 = 1,0 toggling at clk/2.
REQ-032 en dropped at cnt=0 with N=5 -> remaining 4 cycles complete; clk_div_50 low half a cycle after clk_div falls; IDLE follows. en re-raised -> restart at cnt=0 with tick.
REQ-033 reset pulsed low mid-high phase with N=255 -> all outputs 0 immediately. After release and en=1 -> 127 high cycles, 128 low cycles on clk_div; clk_div_50 high 127.5 cycles.

Source files
------------

// File: rtl/clk_divider_n.sv
// Programmable integer clock divider with a posedge-registered output and a
// 50%-duty companion output; divisor changes only take effect at period boundaries.
module clk_divider_n #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_div,
    output logic             clk_div_50,
    output logic [WIDTH-1:0] div_active,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RESET_DIV_C =
        (RESET_DIV < 2) ? WIDTH'(2) : WIDTH'(RESET_DIV);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic             odd_q, odd_d;
    logic             neg_q;
    logic [WIDTH-1:0] load_val;
    logic             boundary;
    logic             run_d;

    // Divisors of 0 or 1 cannot produce a clock; store them as 2.
    assign load_val = (div_val[WIDTH-1:1] == '0) ? WIDTH'(2) : div_val;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        pending_d    = pending_q;
        boundary     = (state_q == StRun) && (cnt_q == div_active_q - 1'b1);

        if (div_load) begin
            pending_d = load_val;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (div_load) begin
                    div_active_d = load_val;
                end
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (boundary) begin
                    // Boundary adopts the pending value held before this edge.
                    cnt_d        = '0;
                    div_active_d = pending_q;
                    if (!en) begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so decode them from next-state values.
        run_d     = (state_d == StRun);
        clk_div_d = run_d && (cnt_d < (div_active_d >> 1));
        tick_d    = run_d && (cnt_d == '0);
        odd_d     = div_active_d[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            div_active_q <= RESET_DIV_C;
            pending_q    <= RESET_DIV_C;
            clk_div_q    <= 1'b0;
            tick_q       <= 1'b0;
            odd_q        <= RESET_DIV_C[0];
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            pending_q    <= pending_d;
            clk_div_q    <= clk_div_d;
            tick_q       <= tick_d;
            odd_q        <= odd_d;
        end
    end

    // Half-cycle delayed copy stretches the high phase by 0.5 clk for odd N.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= clk_div_q;
        end
    end

    assign clk_div    = clk_div_q;
    assign clk_div_50 = clk_div_q | (odd_q & neg_q);
    assign div_active = div_active_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_clk_divider_n.sv
// Scoreboard bench for clk_divider_n: stimulus queues per-cycle expectations,
// a monitor samples each cycle's outputs (both clock halves) and compares.
module tb_clk_divider_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       clk_div;
    logic       clk_div_50;
    logic [7:0] div_active;
    logic       tick;

    typedef struct {
        int         tag;
        logic [3:0] fl;   // {clk_div, clk_div_50 first half, clk_div_50 second half, tick}
        logic [7:0] act;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    clk_divider_n #(
        .WIDTH     (8),
        .RESET_DIV (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .div_val    (div_val),
        .div_load   (div_load),
        .clk_div    (clk_div),
        .clk_div_50 (clk_div_50),
        .div_active (div_active),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    task automatic step(input logic e, input logic ld, input logic [7:0] v,
                        input logic [3:0] fl, input logic [7:0] act, input string name);
        exp_t x;
        @(negedge clk);
        en       = e;
        div_load = ld;
        div_val  = v;
        x.tag  = cyc + 1;
        x.fl   = fl;
        x.act  = act;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_async", {1'b0, clk_div, clk_div_50, tick, div_active}, {4'b0000, 8'd3});
        @(posedge clk);
        #2;
        chk("rst_hold", {1'b0, clk_div, clk_div_50, tick, div_active}, {4'b0000, 8'd3});
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
    endtask

    // Monitor
    initial begin
        logic       dv_s, a_s, b_s, tk_s;
        logic [7:0] act_s;
        exp_t       e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            dv_s  = clk_div;
            a_s   = clk_div_50;
            tk_s  = tick;
            act_s = div_active;
            @(negedge clk);
            #2;
            b_s = clk_div_50;
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                if (e.tag < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s stale: tag %0d at cyc %0d", e.name, e.tag, cyc);
                end else begin
                    chk(e.name, {dv_s, a_s, b_s, tk_s, act_s}, {e.fl, e.act});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;
        #1 reset = 1'b0;
        #1;
        chk("reset_state", {1'b0, clk_div, clk_div_50, tick, div_active}, {4'b0000, 8'd3});
        repeat (2) @(negedge clk);
        reset = 1'b1;

        step(0, 0, 0, 4'b0000, 3, "idle");
        // N=3 free run
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 4'b1111, 3, "n3_c0");
            step(1, 0, 0, 4'b0100, 3, "n3_c1");
            step(1, 0, 0, 4'b0000, 3, "n3_c2");
        end
        // load 4 during cnt=1: period completes at N=3
        step(1, 0, 0, 4'b1111, 3, "ld4_c0");
        step(1, 0, 0, 4'b0100, 3, "ld4_c1");
        step(1, 1, 4, 4'b0000, 3, "ld4_c2");
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 4'b1111, 4, "n4_c0");
            step(1, 0, 0, 4'b1110, 4, "n4_c1");
            step(1, 0, 0, 4'b0000, 4, "n4_c2");
            step(1, 0, 0, 4'b0000, 4, "n4_c3");
        end
        // load 5 then 7 in one period
        step(1, 0, 0, 4'b1111, 4, "l57_c0");
        step(1, 1, 5, 4'b1110, 4, "l57_c1");
        step(1, 1, 7, 4'b0000, 4, "l57_c2");
        step(1, 0, 0, 4'b0000, 4, "l57_c3");
        step(1, 0, 0, 4'b1111, 7, "n7_c0");
        step(1, 0, 0, 4'b1110, 7, "n7_c1");
        step(1, 0, 0, 4'b1110, 7, "n7_c2");
        step(1, 0, 0, 4'b0100, 7, "n7_c3");
        step(1, 0, 0, 4'b0000, 7, "n7_c4");
        step(1, 0, 0, 4'b0000, 7, "n7_c5");
        step(1, 0, 0, 4'b0000, 7, "n7_c6");
        // load 9 on the boundary edge: one more N=7 period
        step(1, 1, 9, 4'b1111, 7, "l9b_c0");
        step(1, 0, 0, 4'b1110, 7, "l9b_c1");
        step(1, 0, 0, 4'b1110, 7, "l9b_c2");
        step(1, 0, 0, 4'b0100, 7, "l9b_c3");
        step(1, 0, 0, 4'b0000, 7, "l9b_c4");
        step(1, 0, 0, 4'b0000, 7, "l9b_c5");
        step(1, 0, 0, 4'b0000, 7, "l9b_c6");
        // N=9, load 0 at cnt=1 -> clamps to 2
        step(1, 0, 0, 4'b1111, 9, "n9_c0");
        step(1, 1, 0, 4'b1110, 9, "n9_c1");
        step(1, 0, 0, 4'b1110, 9, "n9_c2");
        step(1, 0, 0, 4'b1110, 9, "n9_c3");
        step(1, 0, 0, 4'b0100, 9, "n9_c4");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'b0000, 9, "n9_lo");
        step(1, 0, 0, 4'b1111, 2, "n2_c0");
        step(1, 0, 0, 4'b0000, 2, "n2_c1");
        step(1, 0, 0, 4'b1111, 2, "n2_c0");
        step(1, 1, 5, 4'b0000, 2, "n2_ld5");
        // N=5, en dropped during cnt=0
        step(1, 0, 0, 4'b1111, 5, "n5_c0");
        step(0, 0, 0, 4'b1110, 5, "n5_c1");
        step(0, 0, 0, 4'b0100, 5, "n5_c2");
        step(0, 0, 0, 4'b0000, 5, "n5_c3");
        step(0, 0, 0, 4'b0000, 5, "n5_c4");
        step(0, 0, 0, 4'b0000, 5, "n5_idle");
        step(0, 0, 0, 4'b0000, 5, "n5_idle");
        // load 1 in IDLE -> 2 immediately, then restart with tick
        step(0, 1, 1, 4'b0000, 2, "ld1_idle");
        step(1, 0, 0, 4'b1111, 2, "restart_c0");
        step(1, 0, 0, 4'b0000, 2, "restart_c1");
        step(1, 0, 0, 4'b1111, 2, "restart_c0");
        step(0, 0, 0, 4'b0000, 2, "restart_c1");
        step(0, 0, 0, 4'b0000, 2, "stop_idle");
        // N=255, reset mid high phase
        step(0, 1, 255, 4'b0000, 255, "ld255");
        step(1, 0, 0, 4'b1111, 255, "n255_c0");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 4'b1110, 255, "n255_hi");
        div_load = 1'b0;
        pulse_reset();
        step(0, 1, 255, 4'b0000, 255, "ld255_rst");
        step(1, 0, 0, 4'b1111, 255, "p255_c0");
        for (int i = 0; i < 126; i++) step(1, 0, 0, 4'b1110, 255, "p255_hi");
        step(1, 0, 0, 4'b0100, 255, "p255_fall");
        for (int i = 0; i < 127; i++) step(1, 0, 0, 4'b0000, 255, "p255_lo");
        step(0, 0, 0, 4'b0000, 255, "p255_end");
        step(0, 0, 0, 4'b0000, 255, "p255_idle");

        repeat (3) @(posedge clk);
        #8;
        chk("sb_drain", 12'(sb.size()), 12'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
